updown_counter_arbiter: RTL and testbench
=========================================

# updown_counter_arbiter

Round-robin arbiter and sequencer that shares one wrapping up/down counter between two requesters. Each requester issues a stepping command: a direction and a step count. The block grants one command at a time and steps the counter once per clock until the count is exhausted, then pulses a completion flag. It sits between the lab's control logic and the counter display path, and it owns the counter state.

## Interface
- CNT_WIDTH, 2, width of the shared counter (wraps modulo 2^CNT_WIDTH)
- STEP_WIDTH, 4, width of the step-count field of a command

- stepClk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 command request (level)
- dir0  input  1  requester 0 direction: 1 = up, 0 = down
- steps0  input  STEP_WIDTH  requester 0 step count
- req1  input  1  requester 1 command request (level)
- dir1  input  1  requester 1 direction
- steps1  input  STEP_WIDTH  requester 1 step count
- gnt0, gnt1  output  1  one-cycle grant pulse, per requester
- done0, done1  output  1  one-cycle completion pulse, per requester
- busy  output  1  high whenever the state is not IDLE
- UpDown  output  1  direction of the command in progress
- cnt_out  output  CNT_WIDTH  shared counter value

## Operation
- States are IDLE, RUN and DONE. All outputs are registered.
- Reset state: IDLE, cnt_out=0, gnt*=0, done*=0, busy=0, UpDown=0.
- Reset sets the round-robin pointer "last=1", so requester 0 wins the first tie.
- IDLE, arbitration:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester that is not "last" wins.
  - The winning edge latches the winner's dir into UpDown and its steps into the remaining counter (rem), and sets the winner's gnt to 1.
  - Next state is RUN if steps≠0, DONE if steps=0.
- RUN, every edge:
  - cnt_out steps ±1 (modulo 2^CNT_WIDTH). UP from max gives 0; DOWN from 0 gives 2^CNT_WIDTH−1.
  - rem decrements by 1.
  - gnt clears.
  - When the step that makes rem=0 occurs, next state is DONE.
- DONE: the winner's done is high for this one cycle. On the next edge: last = winner, state = IDLE, done clears.
- dir*/steps* are sampled only on the grant edge. Later changes have no effect on the command in progress.
- Requests are ignored while busy. Requesters must keep req high until they see gnt.
- A req still high in IDLE is a new request. A requester that keeps req high is served again. If both requesters are high, they alternate.
- Reset mid-command aborts it: no done pulse, cnt_out=0, last=1.
- gnt0/gnt1 are never high together, and neither are done0/done1.

## Timing
- Let E0 be the edge at which IDLE sees a request, and N the latched step count.
- gnt is high in the cycle after E0.
- For N≥1:
  - cnt_out updates at edges E1..EN.
  - done is high in the cycle after EN.
  - The state is IDLE after edge EN+1.
  - The earliest next grant edge is EN+2.
  - busy is high for N+1 cycles.
- For N=0: gnt and done are high in the same cycle after E0, cnt_out is unchanged, busy is high for 1 cycle, and IDLE resumes after E1.
- Latency from a request being sampled to its first counter change is 1 edge.

## Test plan
- **Reset.** Hold reset for 2 edges with both req high. Required: cnt_out=0, busy=0, gnt*/done*=0 on every edge; no grant until reset falls.
- **Up with wrap.** With CNT_WIDTH=2 and cnt_out=0, drive req0, dir0=1, steps0=5. Required:
  - gnt0 for exactly 1 cycle.
  - cnt_out 1,2,3,0,1 on successive edges.
  - done0 for 1 cycle with cnt_out=1.
  - busy for 6 cycles; UpDown=1.
- **Down with wrap.** From cnt_out=0, drive req1, dir1=0, steps1=3. Required: cnt_out 3,2,1; done1 pulse; gnt0/done0 stay 0.
- **Simultaneous requests.** After reset, hold req0=req1=1 (each dir=1, steps=2). Required:
  - Grant order is gnt0, gnt1, gnt0, ….
  - Each grant occurs 2 edges after the previous done.
  - cnt_out advances 2 per command.
- **Zero steps.** Drive req0 with steps0=0. Required: gnt0 and done0 high in the same cycle, cnt_out unchanged, busy for 1 cycle.
- **Reset mid-command.** Start req1, steps1=10, and assert reset at the 4th RUN edge. Required:
  - No done1.
  - cnt_out=0 and busy=0.
  - A following simultaneous request grants requester 0 first.

Source files
------------

// File: rtl/updown_counter_arbiter_if.sv
// Command/status bundle between the two requesters and the shared up/down counter sequencer.
interface updown_counter_arbiter_if #(
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned STEP_WIDTH = 4
);
  logic                  req0;
  logic                  dir0;
  logic [STEP_WIDTH-1:0] steps0;
  logic                  req1;
  logic                  dir1;
  logic [STEP_WIDTH-1:0] steps1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic                  busy;
  logic                  UpDown;
  logic [CNT_WIDTH-1:0]  cnt_out;

  modport master (
    output req0, dir0, steps0, req1, dir1, steps1,
    input  gnt0, gnt1, done0, done1, busy, UpDown, cnt_out
  );

  modport slave (
    input  req0, dir0, steps0, req1, dir1, steps1,
    output gnt0, gnt1, done0, done1, busy, UpDown, cnt_out
  );
endinterface

// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter granting one stepping command at a time to a shared wrapping
// up/down counter; steps once per clock and pulses done when the count runs out.
module updown_counter_arbiter #(
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned STEP_WIDTH = 4
) (
  input logic                      stepClk,
  input logic                      reset,
  updown_counter_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_d;
  logic [STEP_WIDTH-1:0] r_rem, w_rem_d;
  logic                  r_last, w_last_d;
  logic                  r_win, w_win_d;
  logic                  r_updown, w_updown_d;
  logic                  r_gnt0, w_gnt0_d;
  logic                  r_gnt1, w_gnt1_d;
  logic                  r_done0, w_done0_d;
  logic                  r_done1, w_done1_d;

  logic                  w_pick;
  logic                  w_dir_pick;
  logic [STEP_WIDTH-1:0] w_steps_pick;

  // Requester 1 wins when alone, or on a tie when requester 1 was not served last.
  assign w_pick       = bus.req1 & (~bus.req0 | ~r_last);
  assign w_dir_pick   = w_pick ? bus.dir1 : bus.dir0;
  assign w_steps_pick = w_pick ? bus.steps1 : bus.steps0;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_rem_d    = r_rem;
    w_last_d   = r_last;
    w_win_d    = r_win;
    w_updown_d = r_updown;
    w_gnt0_d   = 1'b0;
    w_gnt1_d   = 1'b0;
    w_done0_d  = 1'b0;
    w_done1_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.req0 | bus.req1) begin
          w_win_d    = w_pick;
          w_updown_d = w_dir_pick;
          w_rem_d    = w_steps_pick;
          w_gnt0_d   = ~w_pick;
          w_gnt1_d   = w_pick;
          if (w_steps_pick == '0) begin
            w_state_d = StDone;
            w_done0_d = ~w_pick;
            w_done1_d = w_pick;
          end else begin
            w_state_d = StRun;
          end
        end
      end
      StRun: begin
        w_cnt_d = r_updown ? r_cnt + CNT_WIDTH'(1) : r_cnt - CNT_WIDTH'(1);
        w_rem_d = r_rem - STEP_WIDTH'(1);
        if (r_rem == STEP_WIDTH'(1)) begin
          w_state_d = StDone;
          w_done0_d = ~r_win;
          w_done1_d = r_win;
        end
      end
      StDone: begin
        w_last_d  = r_win;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge stepClk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_last   <= 1'b1;
      r_win    <= 1'b0;
      r_updown <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_rem    <= w_rem_d;
      r_last   <= w_last_d;
      r_win    <= w_win_d;
      r_updown <= w_updown_d;
      r_gnt0   <= w_gnt0_d;
      r_gnt1   <= w_gnt1_d;
      r_done0  <= w_done0_d;
      r_done1  <= w_done1_d;
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.busy    = (r_state != StIdle);
  assign bus.UpDown  = r_updown;
  assign bus.cnt_out = r_cnt;

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Bench for updown_counter_arbiter: table of single commands, hand-written corner
// sequences, then random traffic against a command-level schedule model.
module tb_updown_counter_arbiter;
  localparam int CW   = 2;
  localparam int SW   = 4;
  localparam int MASK = (1 << CW) - 1;

  logic stepClk = 1'b0;
  logic reset   = 1'b1;

  updown_counter_arbiter_if #(.CNT_WIDTH(CW), .STEP_WIDTH(SW)) bus ();

  updown_counter_arbiter #(.CNT_WIDTH(CW), .STEP_WIDTH(SW)) dut (
    .stepClk (stepClk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 stepClk = ~stepClk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.dir0 = 1'b0; bus.steps0 = '0;
    bus.req1 = 1'b0; bus.dir1 = 1'b0; bus.steps1 = '0;
  endtask

  // Two reset edges with both requests high; nothing may be granted.
  task automatic do_reset();
    @(negedge stepClk);
    reset = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (2) begin
      @(posedge stepClk);
      @(negedge stepClk);
      chk("reset cnt_out", int'(bus.cnt_out), 0);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset gnt", int'({bus.gnt0, bus.gnt1}), 0);
      chk("reset done", int'({bus.done0, bus.done1}), 0);
      chk("reset UpDown", int'(bus.UpDown), 0);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  typedef struct {
    bit       r0;
    bit       d0;
    bit [3:0] s0;
    bit       r1;
    bit       d1;
    bit [3:0] s1;
    int       exp_win;
    int       exp_cnt;
    int       exp_busy;
    int       exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx);
    vec_t v;
    int n_gnt, n_done, gid, did, busy_n, gnt_c, done_c, ud;
    bit fin;
    v = vecs[idx];
    do_reset();
    bus.req0 = v.r0; bus.dir0 = v.d0; bus.steps0 = v.s0;
    bus.req1 = v.r1; bus.dir1 = v.d1; bus.steps1 = v.s1;
    n_gnt = 0; n_done = 0; gid = -1; did = -1; busy_n = 0;
    gnt_c = -1; done_c = -1; ud = -1; fin = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge stepClk);
      @(negedge stepClk);
      if (bus.gnt0 || bus.gnt1) begin
        n_gnt += int'(bus.gnt0) + int'(bus.gnt1);
        gid = int'(bus.gnt1);
        gnt_c = c;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      if (bus.done0 || bus.done1) begin
        n_done += int'(bus.done0) + int'(bus.done1);
        did = int'(bus.done1);
        done_c = c;
      end
      if (bus.busy) begin
        busy_n++;
        ud = int'(bus.UpDown);
      end else if (busy_n > 0) begin
        fin = 1'b1;
        break;
      end
    end
    chk($sformatf("vec%0d completes", idx), int'(fin), 1);
    chk($sformatf("vec%0d grant id", idx), gid, v.exp_win);
    chk($sformatf("vec%0d done id", idx), did, v.exp_win);
    chk($sformatf("vec%0d grant count", idx), n_gnt, 1);
    chk($sformatf("vec%0d done count", idx), n_done, 1);
    chk($sformatf("vec%0d busy cycles", idx), busy_n, v.exp_busy);
    chk($sformatf("vec%0d gnt->done", idx), done_c - gnt_c, v.exp_lat);
    chk($sformatf("vec%0d cnt_out", idx), int'(bus.cnt_out), v.exp_cnt);
    chk($sformatf("vec%0d UpDown", idx), ud, v.exp_win != 0 ? int'(v.d1) : int'(v.d0));
  endtask

  // Command-level reference: expands each granted command into its per-cycle outputs.
  typedef struct {
    bit g0, g1, d0, d1, busy, ud;
    int cnt;
    bit fin;
  } exp_t;

  exp_t m_q[$];
  exp_t m_cur;
  int   m_cnt  = 0;
  bit   m_last = 1'b1;
  bit   m_win  = 1'b0;
  bit   m_ud   = 1'b0;

  task automatic model_step();
    int n, endc;
    bit d;
    exp_t r;
    if (reset) begin
      m_q.delete();
      m_cnt = 0; m_last = 1'b1; m_ud = 1'b0;
      m_cur = '{0, 0, 0, 0, 0, 0, 0, 0};
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      if (m_cur.fin) m_last = m_win;
    end else if (bus.req0 || bus.req1) begin
      m_win = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      n = m_win ? int'(bus.steps1) : int'(bus.steps0);
      d = m_win ? bus.dir1 : bus.dir0;
      for (int k = 0; k <= n; k++) begin
        r.g0 = (k == 0) && !m_win;
        r.g1 = (k == 0) && m_win;
        r.d0 = (k == n) && !m_win;
        r.d1 = (k == n) && m_win;
        r.busy = 1'b1;
        r.ud = d;
        r.cnt = (m_cnt + (d ? k : -k)) & MASK;
        r.fin = 1'b0;
        m_q.push_back(r);
      end
      endc = (m_cnt + (d ? n : -n)) & MASK;
      m_q.push_back('{0, 0, 0, 0, 0, d, endc, 1});
      m_cnt = endc;
      m_ud = d;
      m_cur = m_q.pop_front();
    end else begin
      m_cur = '{0, 0, 0, 0, 0, m_ud, m_cnt, 0};
    end
  endtask

  initial begin
    int ord[4], gc[4], dc[4], dcnt[4];
    int ng, nd, act, exp;
    bit seen_done, seen_gnt;

    idle_inputs();
    vecs[0] = '{1, 1, 4'd5,  0, 0, 4'd0, 0, 1, 6,  5};
    vecs[1] = '{0, 0, 4'd0,  1, 0, 4'd3, 1, 1, 4,  3};
    vecs[2] = '{1, 1, 4'd0,  0, 0, 4'd0, 0, 0, 1,  0};
    vecs[3] = '{1, 0, 4'd2,  1, 1, 4'd1, 0, 2, 3,  2};
    vecs[4] = '{0, 0, 4'd0,  1, 1, 4'd7, 1, 3, 8,  7};
    vecs[5] = '{1, 0, 4'd15, 0, 1, 4'd4, 0, 1, 16, 15};

    for (int i = 0; i < 6; i++) run_vec(i);

    // Both requesters held: grants alternate, two edges after each done.
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.steps0 = 4'd2;
    bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.steps1 = 4'd2;
    ng = 0; nd = 0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      @(posedge stepClk);
      @(negedge stepClk);
      if ((bus.gnt0 || bus.gnt1) && ng < 4) begin
        ord[ng] = int'(bus.gnt1); gc[ng] = c; ng++;
      end
      if ((bus.done0 || bus.done1) && nd < 4) begin
        dc[nd] = c; dcnt[nd] = int'(bus.cnt_out); nd++;
      end
    end
    chk("alt done count", nd, 4);
    if (nd == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("alt order %0d", i), ord[i], i % 2);
        chk($sformatf("alt cnt %0d", i), dcnt[i], (2 * (i + 1)) & MASK);
        if (i > 0) chk($sformatf("alt gap %0d", i), gc[i] - dc[i-1], 2);
      end
    end
    idle_inputs();

    // Reset lands on the 4th RUN edge of a 10-step command.
    do_reset();
    bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.steps1 = 4'd10;
    seen_gnt = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 5 && !seen_gnt; c++) begin
      @(posedge stepClk);
      @(negedge stepClk);
      seen_gnt = bus.gnt1;
    end
    chk("mid gnt1 seen", int'(seen_gnt), 1);
    bus.req1 = 1'b0;
    repeat (3) begin
      @(posedge stepClk);
      @(negedge stepClk);
      if (bus.done1) seen_done = 1'b1;
    end
    chk("mid cnt before reset", int'(bus.cnt_out), 3);
    reset = 1'b1;
    @(posedge stepClk);
    @(negedge stepClk);
    if (bus.done1) seen_done = 1'b1;
    chk("mid cnt after reset", int'(bus.cnt_out), 0);
    chk("mid busy after reset", int'(bus.busy), 0);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.steps0 = 4'd1;
    bus.req1 = 1'b1; bus.steps1 = 4'd1;
    seen_gnt = 1'b0;
    act = -1;
    for (int c = 0; c < 5 && !seen_gnt; c++) begin
      @(posedge stepClk);
      @(negedge stepClk);
      if (bus.done1) seen_done = 1'b1;
      if (bus.gnt0 || bus.gnt1) begin
        seen_gnt = 1'b1;
        act = int'(bus.gnt1);
      end
    end
    chk("mid first grant after reset", act, 0);
    chk("mid no done1", int'(seen_done), 0);
    idle_inputs();

    // Random traffic, including mid-command resets and input churn while busy.
    @(negedge stepClk);
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge stepClk);
      model_step();
      @(negedge stepClk);
      act = int'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.UpDown, bus.cnt_out});
      exp = int'({m_cur.g0, m_cur.g1, m_cur.d0, m_cur.d1, m_cur.busy, m_cur.ud, CW'(m_cur.cnt)});
      chk($sformatf("rand cycle %0d {g0,g1,d0,d1,busy,ud,cnt}", i), act, exp);
      reset = ($urandom_range(0, 99) == 0);
      bus.req0   = ($urandom_range(0, 2) != 0);
      bus.req1   = ($urandom_range(0, 2) != 0);
      bus.dir0   = 1'($urandom_range(0, 1));
      bus.dir1   = 1'($urandom_range(0, 1));
      bus.steps0 = SW'($urandom_range(0, 6));
      bus.steps1 = SW'($urandom_range(0, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
